// File: rtl/sharp_line_feeder.sv
// sharp_line_feeder: walks the LS013B7DH01 framebuffer and streams one
// frame (command, per-line address/pixels/dummy, trailer) over valid/ready.
// Optional build macro SHARP_FEEDER_INVERT_EN adds pix_invert, which is
// latched at frame acceptance and inverts the pixel bytes only.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for frame_req
// CMD      | presenting the write-command byte
// ADDR     | presenting the current line number
// RD_ISSUE | one-cycle framebuffer read strobe
// RD_WAIT  | read data arrives, latched into the pixel register
// DATA     | presenting a pixel byte
// DUMMY    | presenting the end-of-line dummy byte (tx_eol)
// TRAILER  | presenting the end-of-frame trailer byte (tx_eof)
// DONE     | one-cycle frame_done pulse
`timescale 1ns/1ps

module sharp_line_feeder #(
  parameter int          H_PIXELS  = 144,
  parameter int          V_LINES   = 168,
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  CMD_WRITE = 8'h80
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic              frame_req,
`ifdef SHARP_FEEDER_INVERT_EN
  input  logic              pix_invert,
`endif
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_eol,
  output logic              tx_eof,
  output logic              frame_done
);

  localparam int BYTES_PER_LINE = H_PIXELS / 8;
  // line register is at least 8 bits wide so line_q[7:0] is always legal
  localparam int LINE_W = ($clog2(V_LINES + 1) > 8) ? $clog2(V_LINES + 1) : 8;
  localparam int BYTE_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_LINE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DATA,
    S_DUMMY,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [LINE_W-1:0] line_q;
  logic [BYTE_W-1:0] byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        pix_q;
  logic              inv_q;

  assign mem_addr = addr_q;

  // state register; reset abandons any frame in flight
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state and Moore/handshake outputs; every output derives from state so
  // an asynchronous reset clears them immediately
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    mem_rd_en  = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_eol     = 1'b0;
    tx_eof     = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_req) state_nx = S_CMD;
      end
      S_CMD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = CMD_WRITE;
        if (tx_ready) state_nx = S_ADDR;
      end
      S_ADDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = line_q[7:0];
        if (tx_ready) state_nx = S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nx  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy     = 1'b1;
        state_nx = S_DATA;
      end
      S_DATA: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = pix_q;
        if (tx_ready) state_nx = (byte_q == BYTE_LAST) ? S_DUMMY : S_RD_ISSUE;
      end
      S_DUMMY: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_eol   = 1'b1;
        if (tx_ready) state_nx = (line_q == LINE_LAST) ? S_TRAILER : S_ADDR;
      end
      S_TRAILER: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
        if (tx_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // line/byte counters and read address; the address advances by one per
  // pixel and row_base tracks (line-1)*BYTES_PER_LINE without a multiplier
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      line_q   <= LINE_W'(1);
      byte_q   <= '0;
      addr_q   <= '0;
      row_base <= '0;
      pix_q    <= 8'h00;
    end else begin
      case (state)
        S_CMD: begin
          if (tx_ready) begin
            line_q   <= LINE_W'(1);
            row_base <= '0;
          end
        end
        S_ADDR: begin
          if (tx_ready) begin
            byte_q <= '0;
            addr_q <= row_base;
          end
        end
        S_RD_WAIT: begin
          pix_q <= mem_rdata ^ {8{inv_q}};
        end
        S_DATA: begin
          if (tx_ready && (byte_q != BYTE_LAST)) begin
            byte_q <= byte_q + BYTE_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_DUMMY: begin
          if (tx_ready && (line_q != LINE_LAST)) begin
            line_q   <= line_q + LINE_W'(1);
            row_base <= row_base + ADDR_W'(BYTES_PER_LINE);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHARP_FEEDER_INVERT_EN
  // invert choice is frozen at acceptance so mid-frame toggles cannot tear a frame
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst)                             inv_q <= 1'b0;
    else if (state == S_IDLE && frame_req) inv_q <= pix_invert;
  end
`else
  assign inv_q = 1'b0;
`endif

endmodule

// File: tb/tb_sharp_line_feeder.sv
// Directed bench for sharp_line_feeder: idle behaviour, full frames with
// ready tied high and randomly throttled, ignored re-requests, mid-frame
// asynchronous reset, and (with SHARP_FEEDER_INVERT_EN) pixel inversion.
`timescale 1ns/1ps

module tb_sharp_line_feeder;

  logic        clk_12mhz = 1'b0;
  logic        rst       = 1'b1;
  logic        frame_req = 1'b0;
  logic        tx_ready  = 1'b0;
  logic [7:0]  mem_rdata;
  logic        busy, mem_rd_en, tx_valid, tx_eol, tx_eof, frame_done;
  logic [11:0] mem_addr;
  logic [7:0]  tx_data;
`ifdef SHARP_FEEDER_INVERT_EN
  logic        pix_invert = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] ram [0:4095];

  always #5 clk_12mhz = ~clk_12mhz;

  sharp_line_feeder dut (
    .clk_12mhz  (clk_12mhz),
    .rst        (rst),
    .frame_req  (frame_req),
`ifdef SHARP_FEEDER_INVERT_EN
    .pix_invert (pix_invert),
`endif
    .busy       (busy),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_eol     (tx_eol),
    .tx_eof     (tx_eof),
    .frame_done (frame_done)
  );

  // synchronous framebuffer: data valid one cycle after the strobe
  always @(posedge clk_12mhz) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  // monitor: records every transfer as {eof, eol, data}, counts pulses/reads,
  // and flags handshake violations
  int          xfer_cnt   = 0;
  int          done_cnt   = 0;
  int          rd_cnt     = 0;
  int          stall_cnt  = 0;
  int          stable_err = 0;
  int          flag_err   = 0;
  logic [11:0] last_rd_addr = 12'd0;
  logic [9:0]  stream [0:16383];
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_word  = 10'd0;

  always @(negedge clk_12mhz) begin
    if ((tx_eol || tx_eof) && !tx_valid) flag_err++;
    if (prev_stall && !rst && (!tx_valid || {tx_eof, tx_eol, tx_data} != prev_word)) stable_err++;
    if (tx_valid && tx_ready) begin
      if (xfer_cnt < 16384) stream[xfer_cnt] = {tx_eof, tx_eol, tx_data};
      xfer_cnt++;
    end
    if (tx_valid && !tx_ready) stall_cnt++;
    prev_stall = tx_valid && !tx_ready;
    prev_word  = {tx_eof, tx_eol, tx_data};
    if (frame_done) done_cnt++;
    if (mem_rd_en) begin
      rd_cnt++;
      last_rd_addr = mem_addr;
    end
  end

  // reference for transfer k of a frame with RAM[i] = i[7:0]
  function automatic logic [9:0] exp_word(input int k);
    int j, ln, pos;
    if (k == 0)    return {2'b00, 8'h80};
    if (k == 3361) return {2'b10, 8'h00};
    j   = k - 1;
    ln  = j / 20;
    pos = j % 20;
    if (pos == 0)  return {2'b00, 8'(ln + 1)};
    if (pos == 19) return {2'b01, 8'h00};
    return {2'b00, 8'((ln * 18 + pos - 1) & 255)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic start_frame();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic run_until(input bit rnd, input bit spam, input int base, input int limit,
                           input int done_base, input int budget, output bit timed_out);
    int c = 0;
    timed_out = 1'b1;
    while (c < budget) begin
      if (done_cnt > done_base || (xfer_cnt - base) >= limit) begin
        timed_out = 1'b0;
        break;
      end
      tx_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      frame_req = spam && (c % 400 == 13);
      tick();
      c++;
    end
    frame_req = 1'b0;
  endtask

  task automatic compare_stream(input int base, input string tag);
    int bad = 0;
    for (int k = 0; k < 3362; k++) begin
      if (stream[base + k] !== exp_word(k)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"},       busy,       0);
    chk({pfx, "_tx_valid"},   tx_valid,   0);
    chk({pfx, "_tx_data"},    tx_data,    0);
    chk({pfx, "_mem_rd_en"},  mem_rd_en,  0);
    chk({pfx, "_mem_addr"},   mem_addr,   0);
    chk({pfx, "_tx_eol"},     tx_eol,     0);
    chk({pfx, "_tx_eof"},     tx_eof,     0);
    chk({pfx, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int  base, db, rb, sb, x0;
    bit  to;
    logic idle_v, idle_b, idle_r, idle_d;

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);

    // reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // idle with ready high
    tx_ready = 1'b1;
    idle_v = 0; idle_b = 0; idle_r = 0; idle_d = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      idle_v |= tx_valid; idle_b |= busy; idle_r |= mem_rd_en; idle_d |= frame_done;
    end
    chk("idle_tx_valid",   idle_v, 0);
    chk("idle_busy",       idle_b, 0);
    chk("idle_mem_rd_en",  idle_r, 0);
    chk("idle_frame_done", idle_d, 0);

    // full frame, ready tied high
    base = xfer_cnt; db = done_cnt; rb = rd_cnt;
    start_frame();
    chk("accept_busy",     busy,     1);
    chk("accept_tx_valid", tx_valid, 1);
    chk("accept_tx_data",  tx_data,  8'h80);
    run_until(1'b0, 1'b0, base, 100000, db, 20000, to);
    chk("f1_timeout",      to,                 0);
    chk("f1_xfers",        xfer_cnt - base,    3362);
    chk("f1_reads",        rd_cnt - rb,        3024);
    chk("f1_last_rd_addr", last_rd_addr,       3023);
    chk("f1_byte0",        stream[base],       10'h080);
    chk("f1_byte1",        stream[base + 1],   10'h001);
    chk("f1_byte2",        stream[base + 2],   10'h000);
    chk("f1_byte19",       stream[base + 19],  10'h011);
    chk("f1_byte20_eol",   stream[base + 20],  10'h100);
    chk("f1_last_eof",     stream[base + 3361], 10'h200);
    compare_stream(base, "f1_stream");
    repeat (5) tick();
    chk("f1_done_once",    done_cnt - db,      1);
    chk("f1_idle_busy",    busy,               0);

    // full frame, ready randomly throttled
    base = xfer_cnt; db = done_cnt; sb = stall_cnt;
    start_frame();
    run_until(1'b1, 1'b0, base, 100000, db, 40000, to);
    tx_ready = 1'b1;
    chk("f2_timeout",     to,               0);
    chk("f2_xfers",       xfer_cnt - base,  3362);
    compare_stream(base, "f2_stream");
    chk("f2_stalls_seen", (stall_cnt - sb) > 0, 1);
    chk("f2_stable",      stable_err,       0);
    chk("f2_flags_valid", flag_err,         0);
    chk("f2_done_once",   done_cnt - db,    1);

    // repeated requests during a frame are ignored
    base = xfer_cnt; db = done_cnt;
    start_frame();
    run_until(1'b0, 1'b1, base, 100000, db, 20000, to);
    chk("f3_timeout",   to,              0);
    chk("f3_xfers",     xfer_cnt - base, 3362);
    x0 = xfer_cnt;
    repeat (20) tick();
    chk("f3_no_second_frame", xfer_cnt - x0, 0);
    chk("f3_done_once",       done_cnt - db, 1);
    chk("f3_idle_busy",       busy,          0);

    // request after frame_done starts a new frame, then reset it at line 50 byte 7
    base = xfer_cnt; db = done_cnt;
    start_frame();
    chk("f4_restart_busy",    busy,    1);
    chk("f4_restart_tx_data", tx_data, 8'h80);
    run_until(1'b0, 1'b0, base, 990, db, 20000, to);
    chk("f4_timeout",      to,                0);
    chk("f4_xfers",        xfer_cnt - base,   990);
    chk("f4_line50_byte7", stream[base + 989], exp_word(989));
    chk("f4_rd_en",        mem_rd_en,         1);
    chk("f4_mem_addr",     mem_addr,          890);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_reset_busy",  busy,     0);
    chk("post_reset_valid", tx_valid, 0);
    base = xfer_cnt; db = done_cnt;
    start_frame();
    run_until(1'b0, 1'b0, base, 100000, db, 20000, to);
    chk("f5_timeout", to,               0);
    chk("f5_byte0",   stream[base],     10'h080);
    chk("f5_byte1",   stream[base + 1], 10'h001);
    chk("f5_xfers",   xfer_cnt - base,  3362);
    compare_stream(base, "f5_stream");

`ifdef SHARP_FEEDER_INVERT_EN
    // inversion latched at acceptance applies to pixel bytes only
    ram[0] = 8'h0F;
    base = xfer_cnt; db = done_cnt;
    pix_invert = 1'b1;
    start_frame();
    pix_invert = 1'b0;
    run_until(1'b0, 1'b0, base, 4, db, 200, to);
    chk("inv_timeout", to,               0);
    chk("inv_byte0",   stream[base],     10'h080);
    chk("inv_byte1",   stream[base + 1], 10'h001);
    chk("inv_byte2",   stream[base + 2], 10'h0F0);
    chk("inv_byte3",   stream[base + 3], 10'h0FE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
